// File: rtl/aes_result_queue.sv
// In-order result queue between the AES compute stage and the XIF result interface.
// Optional `AES_RESULT_QUEUE_KILL_CNT_EN adds a saturating counter of dropped killed entries.
module aes_result_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned X_ID_WIDTH  = 4,
  parameter int unsigned X_RFW_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       enq_valid_i,
  output logic                       enq_ready_o,
  input  logic [X_ID_WIDTH-1:0]      enq_id_i,
  input  logic [4:0]                 enq_rd_i,
  input  logic [X_RFW_WIDTH-1:0]     enq_data_i,
  input  logic                       commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]      commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [X_ID_WIDTH-1:0]      result_id_o,
  output logic [4:0]                 result_rd_o,
  output logic [X_RFW_WIDTH-1:0]     result_data_o,
  output logic                       result_we_o,
  output logic [$clog2(DEPTH):0]     count_o
`ifdef AES_RESULT_QUEUE_KILL_CNT_EN
  ,
  output logic [7:0]                 kill_cnt_o
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef logic [PW-1:0] ptr_t;

  logic [X_ID_WIDTH-1:0]  id_q   [DEPTH];
  logic [4:0]             rd_q   [DEPTH];
  logic [X_RFW_WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]       committed_q;
  logic [DEPTH-1:0]       killed_q;

  ptr_t          head_q;
  ptr_t          tail_q;
  logic [CW-1:0] count_q;

  logic head_occ;
  logic head_commit;
  logic res_valid;
  logic drop;
  logic pop;
  logic push;
  logic commit_hit;
  ptr_t commit_idx;

  assign head_occ    = (count_q != '0);
  assign head_commit = head_occ & committed_q[head_q];
  assign res_valid   = head_commit & ~killed_q[head_q];
  assign drop        = head_commit & killed_q[head_q];
  assign pop         = (res_valid & result_ready_i) | drop;
  assign enq_ready_o = (count_q != CW'(DEPTH));
  assign push        = enq_valid_i & enq_ready_o;

  // Walk from youngest to oldest so the last hit kept is the oldest matching entry.
  // Only entries occupied before this edge are candidates (offset below count).
  always_comb begin
    commit_hit = 1'b0;
    commit_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (commit_valid_i && (CW'(k) < count_q) &&
          !committed_q[head_q + ptr_t'(k)] &&
          (id_q[head_q + ptr_t'(k)] == commit_id_i)) begin
        commit_hit = 1'b1;
        commit_idx = head_q + ptr_t'(k);
      end
    end
  end

  // Push, pop and commit never touch the same slot: a popped head is already
  // committed, and the tail slot is never occupied while push is allowed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      committed_q <= '0;
      killed_q    <= '0;
    end else begin
      if (push) begin
        tail_q              <= tail_q + 1'b1;
        committed_q[tail_q] <= 1'b0;
        killed_q[tail_q]    <= 1'b0;
      end
      if (commit_hit) begin
        committed_q[commit_idx] <= 1'b1;
        killed_q[commit_idx]    <= commit_kill_i;
      end
      if (pop) begin
        head_q              <= head_q + 1'b1;
        committed_q[head_q] <= 1'b0;
        killed_q[head_q]    <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: payload storage has no reset; it is only visible through the occupied
  // head, and leaving it unreset keeps it as plain RAM-style flops.
  always_ff @(posedge clk_i) begin
    if (push) begin
      id_q[tail_q]   <= enq_id_i;
      rd_q[tail_q]   <= enq_rd_i;
      data_q[tail_q] <= enq_data_i;
    end
  end

  assign result_valid_o = res_valid;
  assign result_we_o    = res_valid;
  assign result_id_o    = head_occ ? id_q[head_q]   : '0;
  assign result_rd_o    = head_occ ? rd_q[head_q]   : '0;
  assign result_data_o  = head_occ ? data_q[head_q] : '0;
  assign count_o        = count_q;

`ifdef AES_RESULT_QUEUE_KILL_CNT_EN
  logic [7:0] kill_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      kill_cnt_q <= '0;
    end else if (drop && (kill_cnt_q != 8'hFF)) begin
      kill_cnt_q <= kill_cnt_q + 8'd1;
    end
  end

  assign kill_cnt_o = kill_cnt_q;
`endif

endmodule

// File: tb/tb_aes_result_queue.sv
// Directed self-checking bench for aes_result_queue (default parameters).
module tb_aes_result_queue;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        enq_valid_i;
  logic        enq_ready_o;
  logic [3:0]  enq_id_i;
  logic [4:0]  enq_rd_i;
  logic [31:0] enq_data_i;
  logic        commit_valid_i;
  logic [3:0]  commit_id_i;
  logic        commit_kill_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic [3:0]  result_id_o;
  logic [4:0]  result_rd_o;
  logic [31:0] result_data_o;
  logic        result_we_o;
  logic [2:0]  count_o;
`ifdef AES_RESULT_QUEUE_KILL_CNT_EN
  logic [7:0]  kill_cnt_o;
`endif

  int checks = 0;
  int errors = 0;
  int exp_kill = 0;

  aes_result_queue dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .enq_valid_i    (enq_valid_i),
    .enq_ready_o    (enq_ready_o),
    .enq_id_i       (enq_id_i),
    .enq_rd_i       (enq_rd_i),
    .enq_data_i     (enq_data_i),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_id_o    (result_id_o),
    .result_rd_o    (result_rd_o),
    .result_data_o  (result_data_o),
    .result_we_o    (result_we_o),
    .count_o        (count_o)
`ifdef AES_RESULT_QUEUE_KILL_CNT_EN
    ,
    .kill_cnt_o     (kill_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic enq(input logic v, input logic [3:0] id, input logic [4:0] rd, input logic [31:0] d);
    enq_valid_i = v;
    enq_id_i    = id;
    enq_rd_i    = rd;
    enq_data_i  = d;
  endtask

  task automatic commit(input logic v, input logic [3:0] id, input logic kill);
    commit_valid_i = v;
    commit_id_i    = id;
    commit_kill_i  = kill;
  endtask

  task automatic check_kill();
`ifdef AES_RESULT_QUEUE_KILL_CNT_EN
    check("kill_cnt", 64'(kill_cnt_o), 64'(exp_kill));
`endif
  endtask

  initial begin
    rst_ni = 1'b0;
    enq(1'b0, 4'd0, 5'd0, 32'd0);
    commit(1'b0, 4'd0, 1'b0);
    result_ready_i = 1'b0;
    #12;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_valid", 64'(result_valid_o), 64'd0);
    check("rst_we", 64'(result_we_o), 64'd0);
    check("rst_enq_ready", 64'(enq_ready_o), 64'd1);
    check("rst_data", 64'(result_data_o), 64'd0);
    check_kill();
    #10 rst_ni = 1'b1;
    step();

    // Minimum-latency single result
    result_ready_i = 1'b1;
    enq(1'b1, 4'd3, 5'd5, 32'hDEADBEEF);
    step();
    check("lat_count1", 64'(count_o), 64'd1);
    check("lat_no_early_valid", 64'(result_valid_o), 64'd0);
    enq(1'b0, 4'd0, 5'd0, 32'd0);
    commit(1'b1, 4'd3, 1'b0);
    step();
    commit(1'b0, 4'd0, 1'b0);
    check("lat_valid", 64'(result_valid_o), 64'd1);
    check("lat_id", 64'(result_id_o), 64'd3);
    check("lat_rd", 64'(result_rd_o), 64'd5);
    check("lat_data", 64'(result_data_o), 64'hDEADBEEF);
    check("lat_we", 64'(result_we_o), 64'd1);
    step();
    check("lat_count0", 64'(count_o), 64'd0);
    check("lat_valid_off", 64'(result_valid_o), 64'd0);
    check("empty_data_zero", 64'(result_data_o), 64'd0);

    // Fill, overflow attempt, then drain across the pointer wrap
    result_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enq(1'b1, 4'(i), 5'(i + 1), 32'(32'hA0 + i));
      step();
    end
    check("full_count", 64'(count_o), 64'd4);
    check("full_enq_ready", 64'(enq_ready_o), 64'd0);
    enq(1'b1, 4'd4, 5'd9, 32'hBAD);
    step();
    check("full_no_accept", 64'(count_o), 64'd4);
    enq(1'b0, 4'd0, 5'd0, 32'd0);
    result_ready_i = 1'b1;
    commit(1'b1, 4'd0, 1'b0);
    step();
    check("full_head_valid", 64'(result_valid_o), 64'd1);
    check("full_head_id", 64'(result_id_o), 64'd0);
    check("full_no_bypass", 64'(enq_ready_o), 64'd0);
    for (int i = 1; i < 4; i++) begin
      commit(1'b1, 4'(i), 1'b0);
      step();
      check("drain_valid", 64'(result_valid_o), 64'd1);
      check("drain_id", 64'(result_id_o), 64'(i));
      check("drain_data", 64'(result_data_o), 64'(32'hA0 + i));
      check("drain_count", 64'(count_o), 64'(4 - i));
      check("drain_enq_ready", 64'(enq_ready_o), 64'd1);
    end
    commit(1'b0, 4'd0, 1'b0);
    step();
    check("drain_empty", 64'(count_o), 64'd0);

    // Out-of-order commit, in-order release, enqueue during pop
    enq(1'b1, 4'd1, 5'd11, 32'h1111);
    step();
    enq(1'b1, 4'd2, 5'd12, 32'h2222);
    step();
    enq(1'b0, 4'd0, 5'd0, 32'd0);
    commit(1'b1, 4'd2, 1'b0);
    step();
    check("ooo_blocked", 64'(result_valid_o), 64'd0);
    check("ooo_count", 64'(count_o), 64'd2);
    commit(1'b1, 4'd1, 1'b0);
    step();
    commit(1'b0, 4'd0, 1'b0);
    check("ooo_first_valid", 64'(result_valid_o), 64'd1);
    check("ooo_first_id", 64'(result_id_o), 64'd1);
    enq(1'b1, 4'd5, 5'd15, 32'h5555);
    step();
    enq(1'b0, 4'd0, 5'd0, 32'd0);
    check("pushpop_count", 64'(count_o), 64'd2);
    check("ooo_second_valid", 64'(result_valid_o), 64'd1);
    check("ooo_second_id", 64'(result_id_o), 64'd2);
    check("ooo_second_data", 64'(result_data_o), 64'h2222);
    step();
    check("ooo_after_count", 64'(count_o), 64'd1);
    check("ooo_uncommitted_wait", 64'(result_valid_o), 64'd0);
    commit(1'b1, 4'd5, 1'b1);
    step();
    commit(1'b0, 4'd0, 1'b0);
    check("kill5_no_valid", 64'(result_valid_o), 64'd0);
    step();
    exp_kill++;
    check("kill5_dropped", 64'(count_o), 64'd0);
    check_kill();

    // Killed entry drops without a result
    enq(1'b1, 4'd7, 5'd7, 32'h7777);
    step();
    enq(1'b0, 4'd0, 5'd0, 32'd0);
    commit(1'b1, 4'd7, 1'b1);
    step();
    commit(1'b0, 4'd0, 1'b0);
    check("kill7_no_valid", 64'(result_valid_o), 64'd0);
    check("kill7_still_held", 64'(count_o), 64'd1);
    step();
    exp_kill++;
    check("kill7_no_valid2", 64'(result_valid_o), 64'd0);
    check("kill7_dropped", 64'(count_o), 64'd0);
    check_kill();

    // Backpressure holds the payload stable
    result_ready_i = 1'b0;
    enq(1'b1, 4'hA, 5'd12, 32'h12345678);
    step();
    enq(1'b0, 4'd0, 5'd0, 32'd0);
    commit(1'b1, 4'hA, 1'b0);
    step();
    commit(1'b0, 4'd0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      check("bp_valid", 64'(result_valid_o), 64'd1);
      check("bp_id", 64'(result_id_o), 64'hA);
      check("bp_rd", 64'(result_rd_o), 64'd12);
      check("bp_data", 64'(result_data_o), 64'h12345678);
      check("bp_we", 64'(result_we_o), 64'd1);
      step();
    end
    check("bp_still_valid", 64'(result_valid_o), 64'd1);
    result_ready_i = 1'b1;
    step();
    check("bp_accepted", 64'(count_o), 64'd0);
    check("bp_valid_off", 64'(result_valid_o), 64'd0);

    // Mid-operation reset discards committed results
    result_ready_i = 1'b0;
    enq(1'b1, 4'd1, 5'd1, 32'hC1);
    step();
    enq(1'b1, 4'd2, 5'd2, 32'hC2);
    step();
    enq(1'b0, 4'd0, 5'd0, 32'd0);
    commit(1'b1, 4'd1, 1'b0);
    step();
    commit(1'b1, 4'd2, 1'b0);
    step();
    commit(1'b0, 4'd0, 1'b0);
    check("pre_rst_count", 64'(count_o), 64'd2);
    check("pre_rst_valid", 64'(result_valid_o), 64'd1);
    #1 rst_ni = 1'b0;
    exp_kill = 0;
    #1;
    check("mid_rst_count", 64'(count_o), 64'd0);
    check("mid_rst_valid", 64'(result_valid_o), 64'd0);
    check("mid_rst_we", 64'(result_we_o), 64'd0);
    check("mid_rst_enq_ready", 64'(enq_ready_o), 64'd1);
    check_kill();
    #3 rst_ni = 1'b1;
    result_ready_i = 1'b1;
    step();
    check("post_rst_valid", 64'(result_valid_o), 64'd0);
    check("post_rst_count", 64'(count_o), 64'd0);
    // Commit of id 9 arrives together with its enqueue, so no entry matches yet
    enq(1'b1, 4'd9, 5'd9, 32'h9999);
    commit(1'b1, 4'd9, 1'b0);
    step();
    enq(1'b0, 4'd0, 5'd0, 32'd0);
    commit(1'b0, 4'd0, 1'b0);
    check("stale_commit_count", 64'(count_o), 64'd1);
    check("stale_commit_valid", 64'(result_valid_o), 64'd0);
    step();
    check("stale_commit_ignored", 64'(result_valid_o), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_result_queue.md
AES_RESULT_QUEUE -- requirements
Module: aes_result_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of queue entries; it SHALL be a power of two and at least 2.
REQ-002 The block SHALL have parameter X_ID_WIDTH, default 4, giving the instruction id width.
REQ-003 The block SHALL have parameter X_RFW_WIDTH, default 32, giving the result data width.
REQ-004 The block SHALL have port clk_i, input, 1 bit: clock; reset is rst_ni, asynchronous, active-low.
REQ-005 The block SHALL have port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have ports enq_valid_i (input, 1) and enq_ready_o (output, 1): the enqueue handshake from the AES compute stage.
REQ-007 The block SHALL have ports enq_id_i (input, X_ID_WIDTH), enq_rd_i (input, 5) and enq_data_i (input, X_RFW_WIDTH): the computed instruction's id, destination register and result.
REQ-008 The block SHALL have ports commit_valid_i (input, 1), commit_id_i (input, X_ID_WIDTH) and commit_kill_i (input, 1): the XIF commit transaction.
REQ-009 The block SHALL have ports result_valid_o (output, 1) and result_ready_i (input, 1): the XIF result handshake.
REQ-010 The block SHALL have ports result_id_o (output, X_ID_WIDTH), result_rd_o (output, 5), result_data_o (output, X_RFW_WIDTH) and result_we_o (output, 1): the result payload.
REQ-011 The block SHALL have port count_o, output, $clog2(DEPTH)+1 bits: the number of occupied entries.

Function
REQ-012 The block SHALL store entries in a circular buffer with head and tail pointers; each entry SHALL hold id, rd, data, a committed flag and a killed flag.
REQ-013 enq_ready_o SHALL equal count_o != DEPTH, with no same-cycle bypass of a pop.
- Enqueue occurs when enq_valid_i & enq_ready_o.
- The entry is written at the tail with committed=0 and killed=0.
- The tail increments modulo DEPTH.
REQ-014 A commit SHALL match only entries that are occupied before the current clock edge.
- A commit with commit_valid_i=1 is compared against every occupied, uncommitted entry whose id equals commit_id_i.
- The oldest such entry gets committed=1, and also killed=1 when commit_kill_i=1.
- A commit that matches no entry SHALL be ignored.
REQ-015 result_valid_o SHALL equal occupied(head) & committed(head) & ~killed(head), driven from registered state only, so that it is never combinationally dependent on commit inputs.
REQ-016 The result payload SHALL be driven from the head entry.
- result_id_o, result_rd_o and result_data_o come from the head entry.
- result_we_o equals result_valid_o.
- All four SHALL hold stable while result_valid_o=1 and result_ready_i=0.
REQ-017 The head SHALL pop on result_valid_o & result_ready_i.
REQ-018 A head entry that is both committed and killed SHALL be dropped in one cycle without asserting result_valid_o.
REQ-019 Results SHALL leave the queue strictly in enqueue order; a committed younger entry SHALL wait behind an uncommitted head.
REQ-020 Minimum latency SHALL be: enqueue at edge N, commit sampled at edge N+1, result_valid_o high during the cycle after edge N+1.
REQ-021 A simultaneous enqueue and pop SHALL leave count_o unchanged and advance both pointers.
REQ-022 Pointers SHALL wrap from DEPTH-1 to 0; full and empty SHALL be distinguished by count_o.
REQ-023 A commit targeting the head in the same cycle as that head pops SHALL be ignored, because the popped entry is already committed.

Reset
REQ-024 While rst_ni=0, the following SHALL be asynchronously cleared:
- head, tail and count_o set to 0;
- all committed and killed flags set to 0;
- result_valid_o = 0, result_we_o = 0, enq_ready_o = 1.
REQ-025 A reset asserted mid-operation SHALL discard all entries, including committed-but-unconsumed results, with no further result emitted.
REQ-026 Entry id, rd and data storage need not be reset; outputs SHALL be 0 whenever the queue is empty.

Configuration
REQ-027 With macro AES_RESULT_QUEUE_KILL_CNT_EN defined, the block SHALL add port kill_cnt_o (output, 8 bits).
- The counter increments by one on each killed-entry drop (REQ-018).
- It saturates at 255 and is reset to 0.
REQ-028 Without AES_RESULT_QUEUE_KILL_CNT_EN defined, the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Enqueue id=3 with data=0xDEADBEEF and rd=5, then commit id=3 with kill=0, holding result_ready_i=1 -> result_valid_o high exactly one cycle after the commit edge with id=3, rd=5, data=0xDEADBEEF, we=1; count_o returns to 0.
REQ-030 Fill 4 entries (ids 0-3) -> enq_ready_o=0 and count_o=4; a fifth enq_valid_i is not accepted; commit id=0 and pop -> enq_ready_o=1.
REQ-031 Enqueue ids 1 and 2, commit id=2 before id=1 -> no result until id=1 is committed; then results for id=1 and id=2 come out back to back in that order.
REQ-032 Enqueue id=7, commit id=7 with kill=1 -> result_valid_o never asserts; the entry drops one cycle after the commit; kill_cnt_o=1 when the macro is defined.
REQ-033 Hold result_ready_i=0 for 3 cycles with a committed head -> result_valid_o and the payload stay stable; accept on the 4th cycle.
REQ-034 Assert rst_ni=0 with 2 committed entries pending -> count_o=0 and result_valid_o=0 immediately; after release, no stale result appears and commit id=9 with no matching entry is ignored.
